// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch sequencer: FSM encoding,
// redirect source codes and the default end-of-program instruction word.
package cpu_pkg;

    typedef enum logic [1:0] {
        IFC_RUN   = 2'b00,
        IFC_REDIR = 2'b01,
        IFC_DRAIN = 2'b10,
        IFC_DONE  = 2'b11
    } ifc_state_e;

    localparam logic [1:0] REDIR_NONE = 2'b00;
    localparam logic [1:0] REDIR_BR   = 2'b01;
    localparam logic [1:0] REDIR_J    = 2'b10;
    localparam logic [1:0] REDIR_JR   = 2'b11;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bundle between the fetch sequencer (master) and the IF/ID/imem side (slave).
interface if_fetch_ctrl_if;
    // redir_valid has no ready: a request is taken in the cycle it is seen unless
    // hazard_stall is high, in which case ID holds and re-asserts it later.
    logic        hazard_stall;
    logic        redir_valid;
    logic [1:0]  redir_sel;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic [31:0] inst_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        ifid_we;
    logic        ifid_flush;

    modport master (
        input  hazard_stall, redir_valid, redir_sel,
        input  br_target, j_target, jr_target, inst_in,
        output pc_out, pc_plus4, ifid_we, ifid_flush
    );

    modport slave (
        output hazard_stall, redir_valid, redir_sel,
        output br_target, j_target, jr_target, inst_in,
        input  pc_out, pc_plus4, ifid_we, ifid_flush
    );
endinterface

// File: rtl/if_drain_counter.sv
// Loadable up-counter with clear and enable; tc flags the last drain cycle.
module if_drain_counter
    import cpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic                              en,
    input  logic                              load,
    input  logic [cnt_width(DRAIN_CYCLES)-1:0] load_val,
    output logic [cnt_width(DRAIN_CYCLES)-1:0] count,
    output logic                              tc
);
    localparam int W = cnt_width(DRAIN_CYCLES);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(DRAIN_CYCLES - 1));
endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: owns the PC, arbitrates stalls against redirects, and
// drains the pipeline for a fixed time after program end before raising fin_sign.
module if_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT,
    parameter int          IMEM_WORDS   = 512,
    parameter int          DRAIN_CYCLES = 7
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    if_fetch_ctrl_if.master       bus,
    output logic                  fin_sign,
    output logic [1:0]            state_out
);
    localparam int          CW       = cnt_width(DRAIN_CYCLES);
    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

    ifc_state_e    state, state_next;
    logic [31:0]   pc, pc_next, redir_pc;
    logic          take_redir, halt_hit, cnt_clr, cnt_en, cnt_tc;
    logic [CW-1:0] cnt;

    // Redirects are only accepted from RUN; REDIR masks a repeated request.
    assign take_redir = (state == IFC_RUN) && bus.redir_valid && (bus.redir_sel != REDIR_NONE);
    assign halt_hit   = (bus.inst_in == HALT_WORD) || (pc >= PC_LIMIT);

    always_comb begin
        case (bus.redir_sel)
            REDIR_BR: redir_pc = bus.br_target;
            REDIR_J:  redir_pc = bus.j_target;
            REDIR_JR: redir_pc = bus.jr_target;
            default:  redir_pc = pc;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= IFC_RUN;
            pc       <= RESET_PC;
            fin_sign <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == IFC_DRAIN && cnt_tc) begin
                fin_sign <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IFC_RUN, IFC_REDIR: begin
                if (bus.hazard_stall) begin
                    state_next = state;
                end else if (take_redir) begin
                    pc_next    = redir_pc;
                    state_next = IFC_REDIR;
                end else if (halt_hit) begin
                    cnt_clr    = 1'b1;
                    state_next = IFC_DRAIN;
                end else begin
                    pc_next    = pc + 32'd4;
                    state_next = IFC_RUN;
                end
            end
            IFC_DRAIN: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_next = IFC_DONE;
                end
            end
            default: state_next = IFC_DONE;
        endcase
    end

    always_comb begin
        bus.ifid_we    = 1'b0;
        bus.ifid_flush = 1'b0;
        if (!RESET) begin
            case (state)
                IFC_RUN, IFC_REDIR: begin
                    if (!bus.hazard_stall) begin
                        bus.ifid_we    = 1'b1;
                        bus.ifid_flush = take_redir || halt_hit;
                    end
                end
                IFC_DRAIN: begin
                    bus.ifid_we    = 1'b1;
                    bus.ifid_flush = 1'b1;
                end
                default: begin
                    bus.ifid_we    = 1'b0;
                    bus.ifid_flush = 1'b0;
                end
            endcase
        end
    end

    if_drain_counter #(
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_drain_counter (
        .clk      (CLOCK),
        .rst      (RESET),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .load     (1'b0),
        .load_val ('0),
        .count    (cnt),
        .tc       (cnt_tc)
    );

    assign bus.pc_out   = pc;
    assign bus.pc_plus4 = pc + 32'd4;
    assign state_out    = state;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus random traffic, all checked
// each cycle against a cycle-level behavioural model of the fetch sequencer.
module tb_if_fetch_ctrl;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam logic [31:0] LIMIT = 32'h0000_0800;
    localparam int          DRAIN = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_stall, redir_valid;
    logic [1:0]  redir_sel;
    logic [31:0] br_target, j_target, jr_target, inst_in;
    logic        fin_sign;
    logic [1:0]  state_out;

    int errors = 0;
    int checks = 0;

    // model: mode 0 run, 1 just redirected, 2 draining, 3 done
    logic [31:0] m_pc;
    int          m_mode;
    int          m_drained;
    logic        m_fin;
    bit          m_valid = 1'b0;

    if_fetch_ctrl_if bus ();

    assign bus.hazard_stall = hazard_stall;
    assign bus.redir_valid  = redir_valid;
    assign bus.redir_sel    = redir_sel;
    assign bus.br_target    = br_target;
    assign bus.j_target     = j_target;
    assign bus.jr_target    = jr_target;
    assign bus.inst_in      = inst_in;

    if_fetch_ctrl dut (
        .CLOCK     (clk),
        .RESET     (rst),
        .bus       (bus),
        .fin_sign  (fin_sign),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v = 32'h0000_0020;
        return v;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'hFFFF_FFFC;
            1:       v = 32'h0000_07FC;
            default: v = {21'd0, 9'($urandom_range(0, 300)), 2'b00};
        endcase
        return v;
    endfunction

    task automatic idle_inputs();
        rst          = 1'b0;
        hazard_stall = 1'b0;
        redir_valid  = 1'b0;
        redir_sel    = 2'b00;
        br_target    = rand_target();
        j_target     = rand_target();
        jr_target    = rand_target();
        inst_in      = rand_inst();
    endtask

    // One clock: compare everything at the falling edge, then advance the model.
    task automatic step();
        logic        exp_we, exp_flush, halt, take;
        logic [31:0] exp_p4, tgt;
        @(negedge clk);
        halt = (inst_in == HALT) || (m_pc >= LIMIT);
        take = (m_mode == 0) && redir_valid && (redir_sel != 2'b00);
        tgt  = (redir_sel == 2'b01) ? br_target : (redir_sel == 2'b10) ? j_target : jr_target;
        if (rst) begin
            exp_we = 1'b0; exp_flush = 1'b0;
        end else if (m_mode <= 1) begin
            exp_we    = !hazard_stall;
            exp_flush = !hazard_stall && (take || halt);
        end else begin
            exp_we    = (m_mode == 2);
            exp_flush = (m_mode == 2);
        end
        checks++;
        if (bus.ifid_we !== exp_we) begin
            errors++;
            $display("FAIL ifid_we t=%0t got %b want %b", $time, bus.ifid_we, exp_we);
        end
        checks++;
        if (bus.ifid_flush !== exp_flush) begin
            errors++;
            $display("FAIL ifid_flush t=%0t got %b want %b", $time, bus.ifid_flush, exp_flush);
        end
        if (m_valid) begin
            exp_p4 = m_pc + 32'd4;
            checks++;
            if (bus.pc_out !== m_pc) begin
                errors++;
                $display("FAIL pc_out t=%0t got %h want %h", $time, bus.pc_out, m_pc);
            end
            checks++;
            if (bus.pc_plus4 !== exp_p4) begin
                errors++;
                $display("FAIL pc_plus4 t=%0t got %h want %h", $time, bus.pc_plus4, exp_p4);
            end
            checks++;
            if (state_out !== 2'(m_mode)) begin
                errors++;
                $display("FAIL state t=%0t got %0d want %0d", $time, state_out, m_mode);
            end
            checks++;
            if (fin_sign !== m_fin) begin
                errors++;
                $display("FAIL fin_sign t=%0t got %b want %b", $time, fin_sign, m_fin);
            end
        end
        if (rst) begin
            m_pc = 32'h0; m_mode = 0; m_drained = 0; m_fin = 1'b0; m_valid = 1'b1;
        end else if (m_mode <= 1) begin
            if (hazard_stall) begin
                m_mode = m_mode;
            end else if (take) begin
                m_pc = tgt; m_mode = 1;
            end else if (halt) begin
                m_mode = 2; m_drained = 0;
            end else begin
                m_pc = m_pc + 32'd4; m_mode = 0;
            end
        end else if (m_mode == 2) begin
            m_drained++;
            if (m_drained == DRAIN) begin
                m_mode = 3; m_fin = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_seq(input int n);
        for (int i = 0; i < n; i++) begin
            inst_in = rand_inst();
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.pc_out !== 32'h0 || state_out !== 2'b00 || fin_sign !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got pc=%h st=%0d fin=%b want 0/0/0", bus.pc_out, state_out, fin_sign);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        run_seq(3);
        checks++;
        if (bus.pc_out !== 32'h0000_000C) begin
            errors++;
            $display("FAIL seq_pc got %h want 0000000c", bus.pc_out);
        end
    endtask

    task automatic test_branch();
        do_reset();
        run_seq(2);
        redir_valid = 1'b1; redir_sel = 2'b01; br_target = 32'h40;
        step();
        checks++;
        if (bus.pc_out !== 32'h40 || state_out !== 2'b01) begin
            errors++;
            $display("FAIL branch_pc got %h st=%0d want 00000040 st=1", bus.pc_out, state_out);
        end
        redir_sel = 2'b10; j_target = 32'h200;
        step();
        redir_valid = 1'b0;
        checks++;
        if (bus.pc_out !== 32'h44) begin
            errors++;
            $display("FAIL redir_masked got %h want 00000044", bus.pc_out);
        end
        run_seq(2);
    endtask

    task automatic test_stall_jr();
        do_reset();
        run_seq(4);
        hazard_stall = 1'b1; redir_valid = 1'b1; redir_sel = 2'b11; jr_target = 32'h0000_0124;
        step();
        step();
        checks++;
        if (bus.pc_out !== 32'h10) begin
            errors++;
            $display("FAIL stall_hold got %h want 00000010", bus.pc_out);
        end
        hazard_stall = 1'b0;
        step();
        redir_valid = 1'b0;
        checks++;
        if (bus.pc_out !== 32'h124) begin
            errors++;
            $display("FAIL stall_then_jr got %h want 00000124", bus.pc_out);
        end
        hazard_stall = 1'b1;
        step();
        hazard_stall = 1'b0;
        run_seq(2);
    endtask

    task automatic test_halt_word();
        do_reset();
        run_seq(8);
        inst_in = HALT;
        step();
        for (int i = 0; i < DRAIN; i++) begin
            hazard_stall = 1'($urandom_range(0, 1));
            redir_valid  = 1'($urandom_range(0, 1));
            redir_sel    = 2'($urandom_range(0, 3));
            step();
        end
        checks++;
        if (fin_sign !== 1'b1 || bus.pc_out !== 32'h20 || state_out !== 2'b11) begin
            errors++;
            $display("FAIL halt_done got fin=%b pc=%h st=%0d want 1/00000020/3", fin_sign, bus.pc_out, state_out);
        end
        run_seq(3);
    endtask

    task automatic test_halt_imem();
        do_reset();
        run_seq(512);
        checks++;
        if (bus.pc_out !== LIMIT) begin
            errors++;
            $display("FAIL imem_end_pc got %h want 00000800", bus.pc_out);
        end
        run_seq(DRAIN + 3);
        checks++;
        if (fin_sign !== 1'b1 || bus.pc_out !== LIMIT) begin
            errors++;
            $display("FAIL imem_done got fin=%b pc=%h want 1/00000800", fin_sign, bus.pc_out);
        end
    endtask

    task automatic test_halt_vs_redirect();
        do_reset();
        run_seq(2);
        inst_in = HALT; redir_valid = 1'b1; redir_sel = 2'b10; j_target = 32'h100;
        step();
        redir_valid = 1'b0;
        checks++;
        if (bus.pc_out !== 32'h100 || state_out !== 2'b01) begin
            errors++;
            $display("FAIL halt_squashed got pc=%h st=%0d want 00000100 st=1", bus.pc_out, state_out);
        end
        run_seq(3);
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        inst_in = HALT;
        step();
        run_seq(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.pc_out !== 32'h0 || state_out !== 2'b00 || fin_sign !== 1'b0) begin
            errors++;
            $display("FAIL drain_reset got pc=%h st=%0d fin=%b want 0/0/0", bus.pc_out, state_out, fin_sign);
        end
        run_seq(3);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            hazard_stall = ($urandom_range(0, 3) == 0);
            redir_valid  = ($urandom_range(0, 2) == 0);
            redir_sel    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0) inst_in = HALT;
            if (m_mode == 3 && $urandom_range(0, 3) == 0) rst = 1'b1;
            step();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_stall_jr();
        test_halt_word();
        test_halt_imem();
        test_halt_vs_redirect();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and selects the next PC from sequential, branch, jump and jr sources.
- Arbitrates between ID-stage hazard stalls and taken-redirects, and drives IF/ID write-enable and flush.
- Detects program end (halt word or fetch past the end of instruction memory), drains the pipeline for a fixed number of cycles, then raises a sticky finish flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that marks end of program
IMEM_WORDS, 512, instruction memory depth in words; PC >= 4*IMEM_WORDS is treated as halt
DRAIN_CYCLES, 7, cycles spent draining after halt detection before fin_sign rises (must be >= 1)

Ports:
CLOCK  in  1  system clock, all state updates on posedge
RESET  in  1  synchronous, active-high reset
hazard_stall  in  1  load-use stall request from ID
redir_valid  in  1  taken branch/jump resolved in ID this cycle
redir_sel  in  2  01 branch, 10 j/jal, 11 jr; 00 is ignored
br_target  in  32  branch target address
j_target  in  32  j/jal target address
jr_target  in  32  jr register target
inst_in  in  32  instruction read from instruction memory at pc_out
pc_out  out  32  registered PC, drives instruction memory address
pc_plus4  out  32  pc_out + 4, modulo 2^32
ifid_we  out  1  IF/ID pipeline register write enable
ifid_flush  out  1  load nop into IF/ID this cycle
fin_sign  out  1  registered, sticky program-finished flag
state_out  out  2  current FSM state, for debug

Behaviour:
- States: RUN=00, REDIR=01, DRAIN=10, DONE=11.
- Reset (sync, overrides everything, including mid-drain or DONE):
  - pc_out=RESET_PC, state=RUN, drain count=0, fin_sign=0.
  - ifid_we=0 and ifid_flush=0 during the reset cycle.
- Outputs ifid_we and ifid_flush are combinational from state and inputs. pc_out, fin_sign and state_out are registered.
- Priority in RUN and REDIR: hazard_stall, then redirect, then halt, then sequential.
- hazard_stall=1:
  - pc_out holds, ifid_we=0, ifid_flush=0.
  - Any concurrent redir_valid is ignored; ID holds and re-asserts it later.
  - Halt detection is suppressed that cycle.
- Redirect (RUN only, redir_valid=1, redir_sel != 00, no stall):
  - Next pc_out is br_target, j_target or jr_target per redir_sel.
  - ifid_we=1, ifid_flush=1 to squash the wrong-path fetch.
  - Next state is REDIR. The new PC is visible on pc_out one cycle after the request.
- REDIR: lasts exactly one cycle.
  - redir_valid is masked.
  - PC advances by 4 (unless stalled), ifid_we=1.
  - Halt check applies as in RUN.
  - Next state is RUN unless halt or stall applies. If stalled, remain in REDIR.
- redir_valid with redir_sel=00: treated as no redirect.
- Halt detection (RUN/REDIR, no stall, no accepted redirect):
  - Triggers if inst_in==HALT_WORD or pc_out >= 4*IMEM_WORDS.
  - pc_out freezes, ifid_flush=1, count cleared to 0, next state is DRAIN.
  - A halt word fetched in the same cycle as a taken redirect is wrong-path: it is squashed and does not halt.
- DRAIN:
  - pc_out frozen, ifid_we=1, ifid_flush=1 every cycle.
  - Inputs hazard_stall and redir_valid are ignored.
  - Count increments each cycle. When count==DRAIN_CYCLES-1, next state is DONE and fin_sign<=1 on the same edge.
- DONE: pc_out frozen, ifid_we=0, ifid_flush=0, fin_sign=1 until RESET.
- PC arithmetic: 32-bit unsigned, +4 wraps modulo 2^32. Targets are used unmodified, with no alignment check.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding (IFC_RUN, IFC_REDIR, IFC_DRAIN, IFC_DONE),
  - the redir_sel codes (REDIR_NONE, REDIR_BR, REDIR_J, REDIR_JR),
  - HALT_WORD_DEFAULT.
- One natural sub-module: if_drain_counter, a loadable up-counter with clear, enable and terminal-count output, parameterised by DRAIN_CYCLES.

Test Plan:
- Reset then 3 sequential fetches of non-halt words: pc_out 0, 4, 8, 12; ifid_we=1, ifid_flush=0 throughout.
- At pc_out=8, redir_valid=1, redir_sel=01, br_target=0x40: next pc_out=0x40, ifid_flush=1 in the request cycle. The following cycle is REDIR with redir_valid masked, and pc_out goes to 0x44.
- hazard_stall=1 for 2 cycles at pc_out=0x10 with redir_valid=1, redir_sel=11: pc_out stays 0x10 and ifid_we=0 in both cycles. After the stall drops, pc_out goes to jr_target.
- inst_in=HALT_WORD at pc_out=0x20: PC frozen at 0x20, 7 DRAIN cycles with ifid_flush=1, fin_sign=1 from the 8th edge onward. Also run with pc_out reaching 0x800 (IMEM_WORDS=512): same drain and finish.
- Halt word concurrent with a taken redirect (redir_sel=10, j_target=0x100): no drain, pc_out goes to 0x100.
- RESET asserted in the 3rd DRAIN cycle: next edge gives pc_out=0, state RUN, fin_sign=0, and normal fetch resumes.
